datamem_pipe: RTL and testbench

//  Parametrised, pipelined little-endian data memory. It replaces the single-cycle data memory on the

---
 rtl/datamem_pipe.sv | 183 ++++++++++++++++++
 tb/tb_datamem_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_pipe.sv
// Pipelined little-endian data memory with valid/ready request and response channels.
// Storage is eight byte lanes; aligned accesses of up to 8 bytes never cross an 8-byte word.
module datamem_lane #(
   parameter int WORDS = 128
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(WORDS)-1:0] addr,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata
);
   logic [7:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

module datamem_pipe #(
   parameter int MEM_BYTES  = 1024,
   parameter int RD_LATENCY = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [3:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_write,
   output logic        rsp_error
);
   localparam int AW    = $clog2(MEM_BYTES);
   localparam int WORDS = MEM_BYTES / 8;
   localparam int CW    = $clog2(RSP_DEPTH + 1);
   localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   typedef struct packed {
      logic        write;
      logic        error;
      logic [63:0] data;
   } rsp_t;

   logic              accept, size_ok, misal, oob, err;
   logic [2:0]        off;
   logic [4:0]        end_b;
   logic [7:0]        wr_en;
   logic [63:0]       wr_sh, rd_word, rd_sh, ld_data;
   logic [7:0][7:0]   rd_raw;
   rsp_t              s0_rsp, head;
   logic [RD_LATENCY:1] vld_pipe;
   rsp_t              pipe_q [1:RD_LATENCY];
   rsp_t              fifo_q [RSP_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     fcnt, outst;
   logic              fifo_empty, push, pop, take;

   // ---------------- request decode ----------------
   always_comb begin
      case (req_size)
         4'd1, 4'd2, 4'd4, 4'd8: size_ok = 1'b1;
         default:                size_ok = 1'b0;
      endcase
   end

   assign misal     = |(req_addr[3:0] & (req_size - 4'd1));
   // Compared as "addr > MEM_BYTES - size" so the 64-bit sum can never wrap.
   assign oob       = req_addr > (64'(MEM_BYTES) - 64'(req_size));
   assign err       = !size_ok || misal || oob;
   assign req_ready = !reset && (outst < CW'(RSP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign off       = req_addr[2:0];
   assign end_b     = 5'(off) + 5'(req_size);
   assign wr_sh     = req_wdata << {off, 3'b000};

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < 8; i++)
         wr_en[i] = accept && req_write && !err && (5'(i) >= 5'(off)) && (5'(i) < end_b);
   end

   // ---------------- byte-lane storage ----------------
   for (genvar i = 0; i < 8; i++) begin : g_lane
      datamem_lane #(.WORDS(WORDS)) u_lane (
         .clk   (clk),
         .we    (wr_en[i]),
         .addr  (req_addr[AW-1:3]),
         .wdata (wr_sh[8*i +: 8]),
         .rdata (rd_raw[i])
      );
   end

   assign rd_word = rd_raw;
   assign rd_sh   = rd_word >> {off, 3'b000};

   always_comb begin
      ld_data = rd_sh;
      case (req_size)
         4'd1: ld_data = req_signed ? {{56{rd_sh[7]}},  rd_sh[7:0]}  : {56'd0, rd_sh[7:0]};
         4'd2: ld_data = req_signed ? {{48{rd_sh[15]}}, rd_sh[15:0]} : {48'd0, rd_sh[15:0]};
         4'd4: ld_data = req_signed ? {{32{rd_sh[31]}}, rd_sh[31:0]} : {32'd0, rd_sh[31:0]};
         default: ld_data = rd_sh;
      endcase
   end

   always_comb begin
      s0_rsp.write = req_write;
      s0_rsp.error = err;
      s0_rsp.data  = (err || req_write) ? 64'd0 : ld_data;
   end

   // ---------------- latency pipeline ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= accept;
         for (int s = 2; s <= RD_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_q[1] <= s0_rsp;
      for (int s = 2; s <= RD_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
   end

   // ---------------- response FIFO ----------------
   // An empty FIFO lets the last stage drive rsp_* directly; if it is not
   // taken that cycle it drops into the FIFO and stays at the head unchanged.
   assign fifo_empty = (fcnt == '0);
   assign head       = fifo_empty ? pipe_q[RD_LATENCY] : fifo_q[rd_ptr];
   assign rsp_valid  = !fifo_empty || vld_pipe[RD_LATENCY];
   assign take       = rsp_valid && rsp_ready;
   assign pop        = !fifo_empty && rsp_ready;
   assign push       = vld_pipe[RD_LATENCY] && !(fifo_empty && rsp_ready);

   assign rsp_data  = rsp_valid ? head.data : 64'd0;
   assign rsp_write = rsp_valid && head.write;
   assign rsp_error = rsp_valid && head.error;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr] <= pipe_q[RD_LATENCY];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
         outst  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fcnt <= fcnt + 1'b1;
            2'b01:   fcnt <= fcnt - 1'b1;
            default: fcnt <= fcnt;
         endcase
         case ({accept, take})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
      end
   end

   a_fifo_no_ovf: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && fcnt == CW'(RSP_DEPTH)));
   a_credit_le_depth: assert property (@(posedge clk) disable iff (reset)
      outst <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_datamem_pipe.sv
// Scoreboard bench for datamem_pipe: byte-array model, directed corner cases, random run.
module tb_datamem_pipe;
   localparam int MB = 1024;
   localparam int RL = 2;
   localparam int RD = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
   logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
   logic [3:0]  req_size = 4'd1;
   logic        req_ready, rsp_valid, rsp_write, rsp_error;
   logic [63:0] rsp_data;

   datamem_pipe #(.MEM_BYTES(MB), .RD_LATENCY(RL), .RSP_DEPTH(RD)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_write(rsp_write), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic        e;
      logic [63:0] d;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mm [MB];
   int         checks = 0, failures = 0, cyc = 0;
   bit         rnd_rdy = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input bit w, input logic [63:0] a, input logic [3:0] s,
                                  input bit sg, input logic [63:0] wd);
      exp_t x;
      logic [63:0] v;
      bit e;
      x.w = w; x.d = 64'd0; x.acc = 0; x.lat = 1'b0;
      if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) e = 1'b1;
      else e = (a % 64'(s) != 64'd0) || (({1'b0, a} + 65'(s)) > 65'(MB));
      x.e = e;
      if (!e) begin
         if (w) begin
            for (int i = 0; i < int'(s); i++) mm[int'(a) + i] = wd[8*i +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < int'(s); i++) v[8*i +: 8] = mm[int'(a) + i];
            if (sg && s != 4'd8)
               for (int b = 8 * int'(s); b < 64; b++) v[b] = v[8*int'(s) - 1];
            x.d = v;
         end
      end
      return x;
   endfunction

   function automatic void push(input bit w, input logic [63:0] a, input logic [3:0] s,
                                input bit sg, input logic [63:0] wd);
      exp_t x;
      x = model(w, a, s, sg, wd);
      x.acc = cyc;
      x.lat = (sb.size() == 0);
      sb.push_back(x);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
   end

   // Response monitor: compares on every handshake, checks hold-while-stalled and latency.
   initial begin
      bit head_new = 1'b1, stalled = 1'b0;
      int first_seen = 0;
      logic [63:0] held_d;
      logic [2:0]  held_f;
      exp_t x;
      forever begin
         @(negedge clk);
         if (reset) begin
            head_new = 1'b1;
            stalled  = 1'b0;
         end else begin
            if (stalled) begin
               chk("hold_data", rsp_data, held_d);
               chk("hold_flags", 64'({rsp_valid, rsp_write, rsp_error}), 64'(held_f));
            end
            stalled = 1'b0;
            if (rsp_valid) begin
               if (head_new) begin
                  first_seen = cyc;
                  head_new   = 1'b0;
               end
               if (rsp_ready) begin
                  if (sb.size() == 0) chk("spurious_rsp", 64'd1, 64'd0);
                  else begin
                     x = sb.pop_front();
                     chk("rsp_write", 64'(rsp_write), 64'(x.w));
                     chk("rsp_error", 64'(rsp_error), 64'(x.e));
                     chk("rsp_data", rsp_data, x.d);
                     if (x.lat) chk("latency", 64'(first_seen - x.acc), 64'(RL));
                  end
                  head_new = 1'b1;
               end else begin
                  stalled = 1'b1;
                  held_d  = rsp_data;
                  held_f  = {rsp_valid, rsp_write, rsp_error};
               end
            end
         end
      end
   end

   task automatic req(input bit w, input logic [63:0] a, input logic [3:0] s,
                      input bit sg, input logic [63:0] wd);
      bit done = 1'b0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
      req_signed = sg; req_wdata = wd;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (req_ready) begin
            push(w, a, s, sg, wd);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!done) chk("req_timeout", 64'd0, 64'd1);
   endtask

   task automatic expect_last(input logic [63:0] d);
      if (sb.size() != 0) sb[sb.size() - 1].d = d;
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      for (int n = 0; n < 300 && sb.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit ok;
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit ok;
      logic [3:0]  s;
      logic [63:0] a;
      logic [3:0]  sizes [5];
      sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd8; sizes[4] = 4'd3;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_rsp_write", 64'(rsp_write), 64'd0);
      chk("rst_rsp_error", 64'(rsp_error), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;

      // store/load of a full word with latency check
      rsp_ready = 1'b1;
      req(1'b1, 64'h10, 4'd8, 1'b0, 64'h8877665544332211);
      drain();
      req(1'b0, 64'h10, 4'd8, 1'b0, 64'd0);
      expect_last(64'h8877665544332211);
      drain();

      // extension
      req(1'b0, 64'h17, 4'd1, 1'b1, 64'd0); expect_last(64'hFFFFFFFFFFFFFF88);
      req(1'b0, 64'h17, 4'd1, 1'b0, 64'd0); expect_last(64'h0000000000000088);
      req(1'b0, 64'h14, 4'd4, 1'b1, 64'd0); expect_last(64'hFFFFFFFF88776655);
      req(1'b0, 64'h12, 4'd2, 1'b1, 64'd0); expect_last(64'h0000000000004433);
      drain();

      // error cases and boundaries
      req(1'b1, 64'h12, 4'd4, 1'b0, 64'hDEADBEEFDEADBEEF);
      req(1'b0, 64'h10, 4'd8, 1'b0, 64'd0); expect_last(64'h8877665544332211);
      req(1'b0, 64'(MB - 4), 4'd8, 1'b0, 64'd0);
      req(1'b0, 64'h10, 4'd3, 1'b0, 64'd0);
      req(1'b0, 64'h10, 4'd0, 1'b0, 64'd0);
      req(1'b1, 64'(MB - 8), 4'd8, 1'b0, 64'h0123456789ABCDEF);
      req(1'b0, 64'(MB - 8), 4'd8, 1'b0, 64'd0); expect_last(64'h0123456789ABCDEF);
      req(1'b0, 64'(MB), 4'd1, 1'b0, 64'd0);
      req(1'b0, 64'hFFFFFFFFFFFFFFF8, 4'd8, 1'b0, 64'd0);
      drain();

      // backpressure fill: only RSP_DEPTH accepted
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8; req_signed = 1'b0;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (req_ready) begin
            push(1'b0, 64'h10, 4'd8, 1'b0, 64'd0);
            n++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("fill_accepts", 64'(n), 64'(RD));
      @(negedge clk);
      chk("fill_not_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("pop_cycle_not_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("ready_after_pop", 64'(req_ready), 64'd1);
      drain();

      // accept and pop in the same cycle at outstanding = RSP_DEPTH-1
      rsp_ready = 1'b0;
      for (int k = 0; k < RD - 1; k++) req(1'b0, 64'h14, 4'd4, 1'b0, 64'd0);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = rsp_valid;
      end
      chk("head_arrives", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_addr = 64'h10; req_size = 4'd1; req_signed = 1'b1; req_write = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("simul_ready", 64'(req_ready), 64'd1);
      if (req_ready) push(1'b0, 64'h10, 4'd1, 1'b1, 64'd0);
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      req_addr = 64'h11;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (req_ready) begin
            push(1'b0, 64'h11, 4'd1, 1'b1, 64'd0);
            n++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("simul_one_credit", 64'(n), 64'd1);
      drain();

      // reset with pending responses; committed store survives, reset-time request ignored
      req(1'b1, 64'h40, 4'd8, 1'b0, 64'hA5A5_0000_1234_5678);
      drain();
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) req(1'b0, 64'h10, 4'd8, 1'b0, 64'd0);
      reset = 1'b1;
      sb.delete();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_size = 4'd8;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      req_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      chk("post_rst_no_valid", 64'(n), 64'd0);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      req(1'b0, 64'h40, 4'd8, 1'b0, 64'd0); expect_last(64'hA5A5_0000_1234_5678);
      drain();

      // random run against the byte model
      for (int i = 0; i < MB / 8; i++) req(1'b1, 64'(i * 8), 4'd8, 1'b0, {$urandom, $urandom});
      drain();
      rnd_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         s = sizes[$urandom_range(0, 15) == 0 ? 4 : $urandom_range(0, 3)];
         a = 64'($urandom_range(0, MB - 1)) & ~(64'(s) - 64'd1);
         case ($urandom_range(0, 31))
            0:       a = a + 64'd1;
            1:       a = 64'(MB - 4);
            2:       a = 64'hFFFF_FFFF_FFFF_FFF8;
            default: a = a;
         endcase
         req(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
